beat_gen: RTL and testbench

Beat sequencer for the 8-bit CPU. It generates the one-hot machine-cycle beats `T[7:0]` that the instruction controller combines with decoded opcode lines to form every register and bus strobe. It sits directly upstream of the controller and provides:
- memory wait-state insertion,
- halt on the HALT instruction,
- wait timeout,
- optional single-step.

---
 rtl/beat_gen.sv | 230 +++++++++++++++++++++++
 tb/tb_beat_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/beat_gen.sv
// beat_gen -- machine-cycle beat sequencer for the 8-bit CPU.
//
// Produces the one-hot beats T[7:0] that the instruction controller ANDs with
// decoded opcode lines. Every beat lasts exactly one clock. Memory wait states
// are inserted *before* a beat (T=0 while waiting), so level strobes qualified
// by a beat fire once. A wait that outlasts WAIT_MAX cycles sets the sticky
// wait_err flag and halts the sequencer.
//
// Optional feature macro: BEAT_GEN_STEP_EN
//   defined   : step_mode=1 parks the sequencer in PAUSE at each instruction
//               boundary until a step pulse releases it.
//   undefined : step_mode/step are accepted but ignored; PAUSE never entered.
//
// Parameters:
//   WAIT_MASK  beats preceded by a memory-ready check (bit k guards T[k])
//   WAIT_MAX   wait cycles tolerated before timeout (1..255)
//   CNT_W      width of instr_cnt
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   launches execution from IDLE/HALT (level, sampled per edge)
//   halt        in   decoded HALT opcode line, sampled only during T7
//   mem_rdy     in   memory ready
//   step_mode   in   pause at each instruction boundary (BEAT_GEN_STEP_EN)
//   step        in   one-cycle pulse releasing a paused instruction
//   T           out  one-hot beat, zero when no beat is active
//   running     out  high in RUN or WAIT
//   halted      out  high in HALT
//   instr_done  out  high during T7 of every completed instruction
//   wait_err    out  sticky wait-timeout flag, cleared by start
//   instr_cnt   out  completed-instruction count, wraps silently

module beat_gen #(
  parameter logic [7:0]  WAIT_MASK = 8'b0010_0100,
  parameter int unsigned WAIT_MAX  = 15,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic             mem_rdy,
  input  logic             step_mode,
  input  logic             step,
  output logic [7:0]       T,
  output logic             running,
  output logic             halted,
  output logic             instr_done,
  output logic             wait_err,
  output logic [CNT_W-1:0] instr_cnt
);

  // Sequencer states
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRun   = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StPause = 3'd3;
  localparam logic [2:0] StHalt  = 3'd4;

  localparam logic [2:0] LastBeat = 3'd7;
  localparam logic [7:0] WaitMax  = WAIT_MAX[7:0];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]       state_q, state_d;
  logic [2:0]       idx_q, idx_d;       // current (RUN) or held (WAIT) beat index
  logic [7:0]       wcnt_q, wcnt_d;     // wait cycles elapsed in the current WAIT
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Registered outputs, computed from the next state so they line up with it
  logic [7:0]       t_q, t_d;
  logic             running_q, running_d;
  logic             halted_q, halted_d;
  logic             done_q, done_d;

  // ---------------------------------------------------------------------------
  // Single-step qualification
  // ---------------------------------------------------------------------------
  logic pause_req;  // park at the next instruction boundary
  logic step_go;    // release from PAUSE

`ifdef BEAT_GEN_STEP_EN
  assign pause_req = step_mode;
  assign step_go   = step;
`else
  assign pause_req = 1'b0;
  assign step_go   = 1'b0;
  // Ports kept for a stable interface; nothing consumes them in this build.
  logic unused_step;
  assign unused_step = step_mode ^ step;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic [2:0] nxt_idx;
  logic       nxt_needs_wait;

  // 3-bit wrap makes beat 7 roll over to beat 0, which then gets the same
  // memory-ready check as any other beat.
  assign nxt_idx        = idx_q + 3'd1;
  assign nxt_needs_wait = WAIT_MASK[nxt_idx] & ~mem_rdy;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      StIdle, StHalt: begin
        // Launch goes straight to T0; instr_cnt is deliberately preserved.
        if (start) begin
          state_d = StRun;
          idx_d   = 3'd0;
          err_d   = 1'b0;
        end
      end

      StRun: begin
        if (idx_q == LastBeat) begin
          cnt_d = cnt_q + CNT_W'(1);
        end

        if ((idx_q == LastBeat) && halt) begin
          state_d = StHalt;
        end else if ((idx_q == LastBeat) && pause_req) begin
          state_d = StPause;
        end else begin
          idx_d = nxt_idx;
          if (nxt_needs_wait) begin
            state_d = StWait;
            wcnt_d  = 8'd0;
          end
        end
      end

      StWait: begin
        if (mem_rdy) begin
          // Held index is presented with no extra delay.
          state_d = StRun;
        end else if (wcnt_q == WaitMax) begin
          state_d = StHalt;
          err_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end

      StPause: begin
        // halt is only meaningful during T7, so it is not looked at here.
        if (step_go) begin
          state_d = StRun;
          idx_d   = 3'd0;
        end
      end

      default: begin
        state_d = StIdle;
        idx_d   = 3'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (registered)
  // ---------------------------------------------------------------------------
  always_comb begin
    t_d       = 8'h00;
    running_d = 1'b0;
    halted_d  = 1'b0;
    done_d    = 1'b0;

    case (state_d)
      StRun: begin
        t_d       = 8'h01 << idx_d;
        running_d = 1'b1;
        done_d    = (idx_d == LastBeat);
      end
      StWait: begin
        running_d = 1'b1;
      end
      StHalt: begin
        halted_d = 1'b1;
      end
      default: begin
        t_d = 8'h00;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= 3'd0;
      wcnt_q    <= 8'd0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      t_q       <= 8'h00;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wcnt_q    <= wcnt_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      t_q       <= t_d;
      running_q <= running_d;
      halted_q  <= halted_d;
      done_q    <= done_d;
    end
  end

  assign T          = t_q;
  assign running    = running_q;
  assign halted     = halted_q;
  assign instr_done = done_q;
  assign wait_err   = err_q;
  assign instr_cnt  = cnt_q;

endmodule

// File: tb/tb_beat_gen.sv
// Directed bench for beat_gen with default parameters. Inputs change 1 time
// unit after each rising edge; outputs are sampled at the same point.

module tb_beat_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        halt;
  logic        mem_rdy;
  logic        step_mode;
  logic        step;
  logic [7:0]  t;
  logic        running;
  logic        halted;
  logic        instr_done;
  logic        wait_err;
  logic [15:0] instr_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0_cyc;

  beat_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .halt       (halt),
    .mem_rdy    (mem_rdy),
    .step_mode  (step_mode),
    .step       (step),
    .T          (t),
    .running    (running),
    .halted     (halted),
    .instr_done (instr_done),
    .wait_err   (wait_err),
    .instr_cnt  (instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_t;

    rst_n     = 1'b0;
    start     = 1'b0;
    halt      = 1'b0;
    mem_rdy   = 1'b1;
    step_mode = 1'b0;
    step      = 1'b0;
    tick();
    tick();

    // Reset state
    check_eq("rst_t",    32'(t), 32'h00);
    check_eq("rst_run",  32'(running), 0);
    check_eq("rst_hlt",  32'(halted), 0);
    check_eq("rst_done", 32'(instr_done), 0);
    check_eq("rst_err",  32'(wait_err), 0);
    check_eq("rst_cnt",  32'(instr_cnt), 0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_t", 32'(t), 32'h00);

    // Free-running: 3 back-to-back instructions
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      exp_t = 8'h01 << (i % 8);
      check_eq("seq_t", 32'(t), 32'(exp_t));
      check_eq("seq_done", 32'(instr_done), ((i % 8) == 7) ? 32'd1 : 32'd0);
      tick();
    end
    check_eq("seq_wrap_t", 32'(t), 32'h01);
    check_eq("seq_cnt3", 32'(instr_cnt), 3);
    check_eq("seq_run", 32'(running), 1);

    // Three wait cycles before T2
    t0_cyc = cyc;
    tick();
    check_eq("w_t1", 32'(t), 32'h02);
    mem_rdy = 1'b0;
    tick();
    check_eq("w_1", 32'(t), 32'h00);
    check_eq("w_run", 32'(running), 1);
    tick();
    check_eq("w_2", 32'(t), 32'h00);
    tick();
    check_eq("w_3", 32'(t), 32'h00);
    mem_rdy = 1'b1;
    tick();
    check_eq("w_t2", 32'(t), 32'h04);
    tick();
    check_eq("w_t3", 32'(t), 32'h08);
    for (int k = 4; k < 8; k++) begin
      tick();
      exp_t = 8'h01 << k;
      check_eq("w_tail", 32'(t), 32'(exp_t));
    end
    tick();
    check_eq("w_next_t0", 32'(t), 32'h01);
    check_eq("w_len", cyc - t0_cyc, 11);
    check_eq("w_cnt4", 32'(instr_cnt), 4);

    // Timeout waiting for T5
    for (int k = 1; k < 5; k++) tick();
    check_eq("to_t4", 32'(t), 32'h10);
    mem_rdy = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      check_eq("to_wait_t", 32'(t), 32'h00);
      check_eq("to_wait_hlt", 32'(halted), 0);
      tick();
    end
    check_eq("to_hlt", 32'(halted), 1);
    check_eq("to_err", 32'(wait_err), 1);
    check_eq("to_t", 32'(t), 32'h00);
    check_eq("to_run", 32'(running), 0);
    check_eq("to_cnt", 32'(instr_cnt), 4);
    mem_rdy = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check_eq("rs_t", 32'(t), 32'h01);
    check_eq("rs_err", 32'(wait_err), 0);
    check_eq("rs_hlt", 32'(halted), 0);

    // Halt at T7, concurrent start ignored
    for (int k = 1; k < 8; k++) tick();
    check_eq("h_t7", 32'(t), 32'h80);
    check_eq("h_done", 32'(instr_done), 1);
    halt  = 1'b1;
    start = 1'b1;
    tick();
    halt  = 1'b0;
    start = 1'b0;
    check_eq("h_t", 32'(t), 32'h00);
    check_eq("h_hlt", 32'(halted), 1);
    check_eq("h_done0", 32'(instr_done), 0);
    check_eq("h_cnt5", 32'(instr_cnt), 5);
    tick();
    check_eq("h_stay", 32'(halted), 1);

    // halt outside T7 is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("h2_t0", 32'(t), 32'h01);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check_eq("h2_t1", 32'(t), 32'h02);
    check_eq("h2_hlt", 32'(halted), 0);

    // Asynchronous reset while waiting for T5
    tick();
    tick();
    tick();
    check_eq("r_t4", 32'(t), 32'h10);
    mem_rdy = 1'b0;
    tick();
    tick();
    check_eq("r_wait", 32'(running), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("r_t", 32'(t), 32'h00);
    check_eq("r_run", 32'(running), 0);
    check_eq("r_hlt", 32'(halted), 0);
    check_eq("r_done", 32'(instr_done), 0);
    check_eq("r_err", 32'(wait_err), 0);
    check_eq("r_cnt", 32'(instr_cnt), 0);
    tick();
    rst_n   = 1'b1;
    mem_rdy = 1'b1;
    tick();
    check_eq("r_idle_t", 32'(t), 32'h00);
    check_eq("r_idle_run", 32'(running), 0);

`ifdef BEAT_GEN_STEP_EN
    // Single-step: pause after T7, step during T3 ignored
    step_mode = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check_eq("s_t0", 32'(t), 32'h01);
    tick();
    tick();
    tick();
    check_eq("s_t3", 32'(t), 32'h08);
    step = 1'b1;
    tick();
    step = 1'b0;
    check_eq("s_t4", 32'(t), 32'h10);
    tick();
    tick();
    tick();
    check_eq("s_t7", 32'(t), 32'h80);
    tick();
    check_eq("s_pause_t", 32'(t), 32'h00);
    check_eq("s_pause_run", 32'(running), 0);
    check_eq("s_pause_hlt", 32'(halted), 0);
    check_eq("s_cnt1", 32'(instr_cnt), 1);
    tick();
    tick();
    check_eq("s_hold_t", 32'(t), 32'h00);
    step = 1'b1;
    tick();
    step = 1'b0;
    check_eq("s_go_t0", 32'(t), 32'h01);
    tick();
    check_eq("s_go_t1", 32'(t), 32'h02);
`else
    // Without the step feature step_mode/step have no effect
    step_mode = 1'b1;
    step      = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    step  = 1'b0;
    check_eq("ns_t0", 32'(t), 32'h01);
    for (int k = 1; k < 8; k++) tick();
    check_eq("ns_t7", 32'(t), 32'h80);
    tick();
    check_eq("ns_next_t0", 32'(t), 32'h01);
    check_eq("ns_run", 32'(running), 1);
    check_eq("ns_cnt1", 32'(instr_cnt), 1);
`endif
    step_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
